execute_stage: RTL
==================

# execute_stage

Execute stage of the five-stage pipelined MIPS core. It sits directly upstream of the memory stage. It computes ALU results for the instruction in EX and owns the HI/LO registers with an iterative multiply/divide unit. While a multiply or divide is in progress it raises a stall request. Its outputs are the registered EX/MEM pipeline register, which feeds the memory stage directly.

## Interface
- WIDTH, 32, datapath width
- MD_ITERS, 32, multiply/divide iteration count (equals WIDTH)

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- RegWriteE, jumpE  in  1 each  control from decode
- MemWriteE  in  2  store control
- ALUControlE  in  4  operation code (mips_pkg)
- ALUSrcE  in  1  selects the ALU B operand: 1 = SignImmE, 0 = SrcBE
- WriteRegE  in  5  resolved destination register
- SrcAE, SrcBE, SignImmE, PCPlus4E  in  WIDTH each  forwarded operands, immediate, and PC+4
- FlushE  in  1  turns the current EX instruction into a bubble
- BusyE  out  1  stall request to the hazard unit
- RegWriteM, jumpM  out  1 each  registered control
- MemWriteM  out  2  registered store control
- WriteRegM  out  5  registered destination register
- ALUOutM, WriteDataM, PCPlus4M  out  WIDTH each  registered ALU result, store data (SrcBE), and PC+4

## Operation
- B operand = ALUSrcE ? SignImmE : SrcBE.
- Single-cycle ops:
  - ADD, SUB: wrap, no overflow trap.
  - AND, OR, XOR, NOR.
  - SLT: signed compare, result 1 or 0.
  - SLTU: unsigned compare.
  - MFHI, MFLO: return HI or LO.
- Multi-cycle ops: MULT, MULTU, DIV, DIVU.
  - Result goes to HI/LO only.
  - RegWriteM = 0 for these ops.
- Multiplier: shift-add.
- Divider: restoring.
- Signed variants operate on magnitudes, then fix the sign.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: LO = all-ones, HI = dividend. No exception.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL/DIV when ALUControlE is a mult/div op and FlushE = 0. Operands are latched on this edge.
  - MUL/DIV: one iteration per cycle. Move to DONE after MD_ITERS iterations.
  - DONE: write HI/LO, retire the instruction to M, then go to IDLE.
- BusyE = (state is MUL or DIV) or (state is IDLE and a mult/div op is issuing). It is combinational in the issue cycle.
- While BusyE = 1, the EX/MEM register loads a bubble: RegWriteM = 0, MemWriteM = 0, jumpM = 0. The hazard unit holds the EX inputs stable.
- In DONE the held instruction does not restart.
- FlushE in IDLE: a bubble is loaded into M and no mult/div starts. FlushE is never asserted while BusyE = 1; if it is, it is ignored.

## Timing
- Single-cycle ops: result appears on the M outputs one rising edge after being presented.
- Mult/div issued in cycle 0:
  - BusyE high in cycles 0..32 (33 cycles).
  - Cycle 33 is DONE: BusyE low, HI/LO updated at the end of cycle 33.
  - The next instruction enters EX in cycle 34. MFHI/MFLO in that instruction sees the new values with no extra stall.
- Back-to-back mult/div: the second one issues from IDLE in cycle 34.
- Reset (asynchronous, any time, including mid-iteration):
  - state = IDLE, HI = LO = 0, iteration counter = 0.
  - All M outputs = 0; BusyE = 0 once inputs are idle.
  - The operation in flight is discarded.

## Structure
- Package mips_pkg holds:
  - ALUControl localparams: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLT 0110, SLTU 0111, MULT 1000, MULTU 1001, DIV 1010, DIVU 1011, MFHI 1100, MFLO 1101.
  - The muldiv state encoding.
- One sub-module, muldiv_unit: contains the FSM, the iteration counter, and the HI/LO registers. It presents start/busy/done to execute_stage.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, RegWriteE = 1, WriteRegE = 5 → next edge: ALUOutM = 0x80000000, RegWriteM = 1, WriteRegM = 5.
- SLT and SLTU with A = 0xFFFFFFFF, B = 1 → ALUOutM = 1 and 0 respectively. SW with FlushE = 1 → MemWriteM = 0.
- MULT −3 × 5 → BusyE high exactly 33 cycles, M outputs are bubbles throughout; then MFLO = 0xFFFFFFF1, MFHI = 0xFFFFFFFF.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234.
- rst_n pulsed low during iteration 10 of DIVU → all M outputs 0 and HI = LO = 0 immediately. After release, a fresh ADD completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: ALU operation codes and multiply/divide FSM encoding shared by the execute stage.
package mips_pkg;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
  function automatic logic is_md_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI and LO.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MD_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(MD_ITERS);
  md_state_t state, next;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, prod, p_mul, p_div;
  logic [WIDTH-1:0] bm, a_raw, mag_a, mag_b, quo, rem;
  logic [WIDTH:0] sum, trial, diff;
  logic neg_q, neg_r, is_div, sa, sb, ge, last;
  assign sa    = ~md_op[0] & a[WIDTH-1];
  assign sb    = ~md_op[0] & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;
  assign last  = cnt == CW'(MD_ITERS - 1);
  // p holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  assign sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, bm} : '0);
  assign p_mul = {sum, p[WIDTH-1:1]};
  assign trial = p[2*WIDTH-1:WIDTH-1];
  assign diff  = trial - {1'b0, bm};
  assign ge    = ~diff[WIDTH];
  assign p_div = {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], p[WIDTH-2:0], ge};
  assign prod  = neg_q ? -p : p;
  assign quo   = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem   = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign busy  = (state == MUL) | (state == DIV) | ((state == IDLE) & start);
  assign done  = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = start ? (md_op[1] ? DIV : MUL) : IDLE;
      MUL, DIV: next = last ? DONE : state;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      p      <= '0;
      bm     <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          p      <= {{WIDTH{1'b0}}, mag_a};
          bm     <= mag_b;
          a_raw  <= a;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          is_div <= md_op[1];
          cnt    <= '0;
        end
        MUL: begin
          p   <= p_mul;
          cnt <= cnt + CW'(1);
        end
        DIV: begin
          p   <= p_div;
          cnt <= cnt + CW'(1);
        end
        default: {hi, lo} <= !is_div ? prod : (bm == '0) ? {a_raw, {WIDTH{1'b1}}} : {rem, quo};
      endcase
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU, HI/LO multiply/divide and the EX/MEM pipeline register.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MD_ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteE,
  input  logic             jumpE,
  input  logic [1:0]       MemWriteE,
  input  logic [3:0]       ALUControlE,
  input  logic             ALUSrcE,
  input  logic [4:0]       WriteRegE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] SignImmE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             RegWriteM,
  output logic             jumpM,
  output logic [1:0]       MemWriteM,
  output logic [4:0]       WriteRegM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M
);
  logic [WIDTH-1:0] b, alu, hi, lo;
  logic is_md, start, md_done, bubble;
  assign b      = ALUSrcE ? SignImmE : SrcBE;
  assign is_md  = is_md_op(ALUControlE);
  assign start  = is_md & ~FlushE;
  // a retiring mult/div in DONE is not flushable, matching the ignored flush while busy
  assign bubble = BusyE | (FlushE & ~md_done);
  muldiv_unit #(.WIDTH(WIDTH), .MD_ITERS(MD_ITERS)) u_md (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .md_op(ALUControlE[1:0]),
    .a    (SrcAE),
    .b    (b),
    .busy (BusyE),
    .done (md_done),
    .hi   (hi),
    .lo   (lo)
  );
  always_comb begin
    alu = '0;
    case (ALUControlE)
      ALU_ADD:  alu = SrcAE + b;
      ALU_SUB:  alu = SrcAE - b;
      ALU_AND:  alu = SrcAE & b;
      ALU_OR:   alu = SrcAE | b;
      ALU_XOR:  alu = SrcAE ^ b;
      ALU_NOR:  alu = ~(SrcAE | b);
      ALU_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(SrcAE) < $signed(b)};
      ALU_SLTU: alu = {{(WIDTH-1){1'b0}}, SrcAE < b};
      ALU_MFHI: alu = hi;
      ALU_MFLO: alu = lo;
      default:  alu = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      jumpM      <= 1'b0;
      MemWriteM  <= 2'b00;
      WriteRegM  <= '0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE & ~bubble & ~is_md;
      jumpM      <= jumpE & ~bubble;
      MemWriteM  <= bubble ? 2'b00 : MemWriteE;
      WriteRegM  <= WriteRegE;
      ALUOutM    <= alu;
      WriteDataM <= SrcBE;
      PCPlus4M   <= PCPlus4E;
    end
  end
endmodule
